// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with write-side FIFO, baud timing and a
// frame serialiser. Supports 5-8 data bits, 1/2 stop bits, line break and
// FIFO flush. Optional parity is built only when UART_TX_PARITY_EN is defined.
// Without that macro, parity_en_i/parity_even_i are ignored.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   div_i               baud divisor {DLM,DLL}; 0 is treated as 1
//   data_bits_i         00=5 .. 11=8 data bits
//   stop2_i             two stop bits
//   parity_en_i         parity enable (UART_TX_PARITY_EN builds only)
//   parity_even_i       1=even, 0=odd parity
//   break_i             force tx_o low
//   fifo_clr_i          synchronous FIFO flush
//   wr_valid_i/wr_data_i/wr_ready_o   byte write handshake
//   tx_o                serial line
//   busy_o              frame in progress
//   thre_o              FIFO empty
//   temt_o              FIFO empty and serialiser idle
//   fifo_count_o        FIFO occupancy
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            div_i,
  input  logic [1:0]                  data_bits_i,
  input  logic                        stop2_i,
  input  logic                        parity_en_i,
  input  logic                        parity_even_i,
  input  logic                        break_i,
  input  logic                        fifo_clr_i,
  input  logic                        wr_valid_i,
  input  logic [7:0]                  wr_data_i,
  output logic                        wr_ready_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic                        thre_o,
  output logic                        temt_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = DIV_W + $clog2(OVERSAMPLE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e state_q, state_d;

  // ---------------- FIFO ----------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push, pop;
  logic [7:0]    head;

  assign wr_ready_o = (count_q != (AW+1)'(FIFO_DEPTH));
  // A flush in the same cycle wins over both push and pop.
  assign push = wr_valid_i && wr_ready_o && !fifo_clr_i;
  assign pop  = (state_q == S_IDLE) && (count_q != '0) && !fifo_clr_i;
  assign head = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (fifo_clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------- frame datapath ----------------
  logic [7:0]    sh_q;
  logic [2:0]    last_q;   // index of the last data bit (N-1)
  logic [2:0]    bit_q;
  logic          stop2_q, stop_q;
  logic [CW-1:0] per_q, cnt_q, div_eff, per_d;
  logic          bit_end;

  assign div_eff = (div_i == '0) ? CW'(1) : CW'(div_i);
  assign per_d   = div_eff * CW'(OVERSAMPLE);
  assign bit_end = (cnt_q == per_q - CW'(1));

`ifdef UART_TX_PARITY_EN
  logic       pen_q, par_q;
  logic [7:0] par_mask;
  // Keep only the N data bits that go on the line.
  assign par_mask = 8'hFF >> (2'd3 - data_bits_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pen_q <= 1'b0;
      par_q <= 1'b0;
    end else if (pop) begin
      pen_q <= parity_en_i;
      par_q <= parity_even_i ? ^(head & par_mask) : ~^(head & par_mask);
    end
  end
`else
  logic unused_parity;
  assign unused_parity = parity_en_i ^ parity_even_i;
`endif

  // Format is latched at pop so mid-frame changes apply to the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q    <= '0;
      last_q  <= '0;
      bit_q   <= '0;
      stop2_q <= 1'b0;
      stop_q  <= 1'b0;
      per_q   <= CW'(OVERSAMPLE);
      cnt_q   <= '0;
    end else if (state_q == S_IDLE) begin
      cnt_q <= '0;
      if (pop) begin
        sh_q    <= head;
        last_q  <= 3'd4 + {1'b0, data_bits_i};
        bit_q   <= '0;
        stop2_q <= stop2_i;
        stop_q  <= 1'b0;
        per_q   <= per_d;
      end
    end else begin
      cnt_q <= bit_end ? '0 : cnt_q + CW'(1);
      if (bit_end && state_q == S_DATA) begin
        sh_q  <= sh_q >> 1;
        bit_q <= bit_q + 3'd1;
      end
      if (bit_end && state_q == S_STOP) stop_q <= 1'b1;
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  logic line;

  always_comb begin
    state_d = state_q;
    line    = 1'b1;
    case (state_q)
      S_IDLE:  if (pop) state_d = S_START;
      S_START: begin
        line = 1'b0;
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        line = sh_q[0];
        if (bit_end && bit_q == last_q) begin
`ifdef UART_TX_PARITY_EN
          state_d = pen_q ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        line = par_q;
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP:  if (bit_end && (!stop2_q || stop_q)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Break overrides the line without disturbing frame timing.
  assign tx_o         = line & ~break_i;
  assign busy_o       = (state_q != S_IDLE);
  assign thre_o       = (count_q == '0);
  assign temt_o       = thre_o && !busy_o;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int NV    = 7;

  logic        clk = 1'b0, rst = 1'b1;
  logic [15:0] div_i = 16'd1;
  logic [1:0]  data_bits_i = 2'd3;
  logic        stop2_i = 1'b0, parity_en_i = 1'b0, parity_even_i = 1'b0;
  logic        break_i = 1'b0, fifo_clr_i = 1'b0, wr_valid_i = 1'b0;
  logic [7:0]  wr_data_i = 8'h00;
  logic        wr_ready_o, tx_o, busy_o, thre_o, temt_o;
  logic [4:0]  fifo_count_o;

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(16), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .div_i(div_i), .data_bits_i(data_bits_i),
    .stop2_i(stop2_i), .parity_en_i(parity_en_i), .parity_even_i(parity_even_i),
    .break_i(break_i), .fifo_clr_i(fifo_clr_i), .wr_valid_i(wr_valid_i),
    .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o), .tx_o(tx_o), .busy_o(busy_o),
    .thre_o(thre_o), .temt_o(temt_o), .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  db;
    logic        stop2, pen, peven;
    logic [15:0] div;
    logic [11:0] bits;  // line bits in emission order, start bit at [0]
    int          len;
    int          per;
  } vec_t;

  typedef struct {
    logic [11:0] bits;
    int          len;
    int          per;
  } exp_t;

  exp_t sb[$];
  vec_t vt[NV];
  int   checks = 0, errors = 0, last_end = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] d, output int wc);
    @(negedge clk);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    wc = cyc;
    @(negedge clk);
    wr_valid_i = 1'b0;
  endtask

  task automatic wait_start(input string nm, output int sc);
    int t = 0;
    @(negedge clk);
    while (tx_o !== 1'b0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_start_seen"}, t < 3000, 1);
    sc = cyc;
  endtask

  // Pops one expected frame and checks every cycle of it on the line.
  task automatic check_frame(input string nm, input bit b2b, input bit scramble,
                             input bit last, output int sc);
    exp_t e;
    int nbad, bbad;
    sc = 0;
    if (sb.size() == 0) begin
      chk({nm, "_sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    wait_start(nm, sc);
    if (b2b) chk({nm, "_gap"}, sc - last_end, 2);
    if (scramble) begin
      div_i = 16'd9; data_bits_i = ~data_bits_i; stop2_i = ~stop2_i;
      parity_en_i = ~parity_en_i; parity_even_i = ~parity_even_i;
    end
    bbad = 0;
    for (int i = 0; i < e.len; i++) begin
      nbad = 0;
      for (int c = 0; c < e.per; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (tx_o !== e.bits[i]) nbad++;
        if (busy_o !== 1'b1) bbad++;
      end
      chk($sformatf("%s_bit%0d", nm, i), nbad, 0);
    end
    chk({nm, "_busy_in_frame"}, bbad, 0);
    last_end = cyc;
    @(negedge clk);
    chk({nm, "_idle_tx"}, tx_o, 1);
    chk({nm, "_idle_busy"}, busy_o, 0);
    if (last) chk({nm, "_temt"}, temt_o, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int wc, sc, bad, nb;
    vt[0] = '{8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 16'd1, 12'({1'b1, 8'hA5, 1'b0}), 10, 16};
    vt[1] = '{8'h0F, 2'd0, 1'b0, 1'b0, 1'b0, 16'd0, 12'({1'b1, 5'h0F, 1'b0}), 7, 16};
    vt[6] = '{8'h3C, 2'd3, 1'b1, 1'b0, 1'b0, 16'd1, 12'({2'b11, 8'h3C, 1'b0}), 11, 16};
`ifdef UART_TX_PARITY_EN
    vt[2] = '{8'h83, 2'd2, 1'b1, 1'b1, 1'b1, 16'd2, 12'({2'b11, 1'b0, 7'h03, 1'b0}), 11, 32};
    vt[3] = '{8'h83, 2'd2, 1'b1, 1'b1, 1'b0, 16'd2, 12'({2'b11, 1'b1, 7'h03, 1'b0}), 11, 32};
    vt[4] = '{8'h55, 2'd1, 1'b0, 1'b1, 1'b1, 16'd1, 12'({1'b1, 1'b1, 6'h15, 1'b0}), 9, 16};
    vt[5] = '{8'hFF, 2'd3, 1'b0, 1'b1, 1'b0, 16'd3, 12'({1'b1, 1'b1, 8'hFF, 1'b0}), 11, 48};
`else
    vt[2] = '{8'h83, 2'd2, 1'b1, 1'b1, 1'b1, 16'd2, 12'({2'b11, 7'h03, 1'b0}), 10, 32};
    vt[3] = '{8'h83, 2'd2, 1'b1, 1'b1, 1'b0, 16'd2, 12'({2'b11, 7'h03, 1'b0}), 10, 32};
    vt[4] = '{8'h55, 2'd1, 1'b0, 1'b1, 1'b1, 16'd1, 12'({1'b1, 6'h15, 1'b0}), 8, 16};
    vt[5] = '{8'hFF, 2'd3, 1'b0, 1'b1, 1'b0, 16'd3, 12'({1'b1, 8'hFF, 1'b0}), 10, 48};
`endif

    // Reset values
    #1;
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_thre", thre_o, 1);
    chk("rst_temt", temt_o, 1);
    chk("rst_ready", wr_ready_o, 1);
    chk("rst_count", fifo_count_o, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Table-driven single frames
    for (int r = 0; r < NV; r++) begin
      div_i = vt[r].div; data_bits_i = vt[r].db; stop2_i = vt[r].stop2;
      parity_en_i = vt[r].pen; parity_even_i = vt[r].peven;
      sb.push_back('{vt[r].bits, vt[r].len, vt[r].per});
      write_byte(vt[r].data, wc);
      check_frame($sformatf("vec%0d", r), 1'b0, r[0], 1'b1, sc);
      chk($sformatf("vec%0d_latency", r), sc - wc, 2);
    end

    // FIFO full, 17 back-to-back frames
    div_i = 16'd1; data_bits_i = 2'd3; stop2_i = 1'b0; parity_en_i = 1'b0;
    fork
      begin
        for (int k = 0; k < 17; k++) begin
          @(negedge clk);
          chk($sformatf("full_ready%0d", k), wr_ready_o, 1);
          wr_valid_i = 1'b1;
          wr_data_i  = 8'(k);
          sb.push_back('{12'({1'b1, 8'(k), 1'b0}), 10, 16});
        end
        @(negedge clk);
        wr_valid_i = 1'b0;
        chk("full_ready_low", wr_ready_o, 0);
        chk("full_count", fifo_count_o, 16);
        repeat (50) @(negedge clk);
        chk("full_ready_hold", wr_ready_o, 0);
        chk("full_count_hold", fifo_count_o, 16);
      end
      begin
        @(negedge clk); #1;
        for (int k = 0; k < 17; k++)
          check_frame($sformatf("full%0d", k), k > 0, 1'b0, k == 16, sc);
      end
    join

    // FIFO clear during first frame; clear also beats a same-cycle push
    sb.push_back('{12'({1'b1, 8'h11, 1'b0}), 10, 16});
    fork
      check_frame("clr", 1'b0, 1'b0, 1'b1, sc);
      begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          wr_valid_i = 1'b1;
          wr_data_i  = 8'h11 * 8'(k + 1);
        end
        @(negedge clk);
        wr_valid_i = 1'b0;
        repeat (30) @(negedge clk);
        chk("clr_count_before", fifo_count_o, 3);
        fifo_clr_i = 1'b1; wr_valid_i = 1'b1; wr_data_i = 8'h99;
        @(negedge clk);
        fifo_clr_i = 1'b0; wr_valid_i = 1'b0;
        chk("clr_count", fifo_count_o, 0);
        chk("clr_thre", thre_o, 1);
        chk("clr_busy", busy_o, 1);
      end
    join
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    chk("clr_nothing_follows", bad, 0);

    // Break mid-frame
    write_byte(8'hA5, wc);
    wait_start("brk", sc);
    bad = 0; nb = 0;
    for (int n = 1; n <= 160; n++) begin
      @(negedge clk);
      if (n == 50) begin
        break_i = 1'b1;
        #1;
        chk("brk_immediate", tx_o, 0);
      end
      if (n == 130) break_i = 1'b0;
      if (break_i && tx_o !== 1'b0) bad++;
      if (n < 160 && busy_o !== 1'b1) nb++;
      if (n == 160) chk("brk_busy_end", busy_o, 0);
    end
    chk("brk_line_low", bad, 0);
    chk("brk_busy_timing", nb, 0);

    // Asynchronous reset mid-DATA with bytes still queued
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      wr_valid_i = 1'b1;
      wr_data_i  = 8'hA5 + 8'(k);
      @(negedge clk);
    end
    wr_valid_i = 1'b0;
    repeat (60) @(negedge clk);
    chk("arst_count_before", fifo_count_o, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_tx", tx_o, 1);
    chk("arst_busy", busy_o, 0);
    chk("arst_count", fifo_count_o, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{12'({1'b1, 8'h55, 1'b0}), 10, 16});
    write_byte(8'h55, wc);
    check_frame("arst_after", 1'b0, 1'b0, 1'b1, sc);
    chk("arst_latency", sc - wc, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter: write-side FIFO, baud generator, frame serialiser in one block.
- Successor to the fixed 8N1 TX path. Adds 5–8 data bits, optional parity, 1/2 stop bits, break, FIFO clear and status outputs.
- Sits between the UART register file (THR writes, LCR/DLL/DLM fields) and the `tx_o` pad.
- Frame timing is anchored to frame start, not to a free-running tick.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of 2, ≥2.
- OVERSAMPLE, 16, clk cycles per bit per divisor unit.
- DIV_W, 16, width of the baud divisor.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- div_i  in  DIV_W  baud divisor {DLM,DLL}; 0 treated as 1.
- data_bits_i  in  2  00=5, 01=6, 10=7, 11=8 data bits.
- stop2_i  in  1  1 = two stop bits.
- parity_en_i  in  1  parity bit enable.
- parity_even_i  in  1  1 = even parity, 0 = odd parity.
- break_i  in  1  force line low.
- fifo_clr_i  in  1  synchronous FIFO flush.
- wr_valid_i  in  1  write request.
- wr_data_i  in  8  byte to enqueue.
- wr_ready_o  out  1  FIFO not full.
- tx_o  out  1  serial line.
- busy_o  out  1  frame in progress.
- thre_o  out  1  FIFO empty.
- temt_o  out  1  FIFO empty and serialiser idle.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: tx_o=1, busy_o=0, thre_o=1, temt_o=1, wr_ready_o=1, fifo_count_o=0; FSM to IDLE; FIFO pointers cleared. Reset mid-frame drives tx_o high immediately (asynchronous).
- FIFO write:
  - Enqueue when wr_valid_i && wr_ready_o.
  - wr_ready_o = (count != FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave count unchanged.
- fifo_clr_i: zeroes pointers and count next cycle and overrides a same-cycle push. It does not abort a frame already loaded in the shifter.
- Bit period: P = max(div_i,1)*OVERSAMPLE clk cycles.
  - Baud counter is cleared on IDLE exit and counts 0..P-1; each bit lasts exactly P cycles.
  - Counter width is DIV_W + $clog2(OVERSAMPLE); no overflow.
- IDLE:
  - Entered when the FIFO is non-empty and not being cleared this cycle: pop the head, latch data and all format inputs (data_bits_i, stop2_i, parity_en_i, parity_even_i, div_i), go to START next cycle.
  - Format changes mid-frame take effect at the next frame.
- START: tx_o=0 for P cycles → DATA.
- DATA:
  - Send N = 5 + data_bits_i bits, LSB first, P cycles each.
  - Upper unused bits of the byte are ignored.
  - After bit N-1 → PARITY if parity is enabled, else STOP.
- PARITY: one bit.
  - Even parity: XOR of the N data bits.
  - Odd parity: inverted XOR of the N data bits.
  - → STOP.
- STOP: tx_o=1 for P cycles, or 2P cycles if stop2 → IDLE.
- Back-to-back frames: exactly one idle clk cycle (tx_o=1) between a frame's last stop cycle and the next start bit.
- busy_o: 1 in every state except IDLE.
- temt_o = thre_o && !busy_o.
- break_i:
  - tx_o forced 0 combinationally while high.
  - FSM, FIFO and counters keep running; frame content sent during break is lost on the line.
- div_i changes while busy have no effect on the current frame.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
  - Defined: PARITY state and the parity_en_i / parity_even_i inputs behave as above.
  - Undefined: PARITY state is not synthesised; parity_en_i and parity_even_i are ignored; frames are always 5–8 data bits, no parity.
- Port list is identical in both builds.

Test Plan:
- 8N1 timing: div=1, OVERSAMPLE=16, write 0xA5 → tx_o low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16 cycles. Start to stop end = 160 cycles; temt_o returns to 1 after stop.
- Parity and 2 stop bits (UART_TX_PARITY_EN defined): div=2, 7 data bits, even parity, stop2; write 0x83 → data 1,1,0,0,0,0,0, parity 0, stop high 64 cycles. Frame = 11 bits × 32 = 352 cycles.
  - Repeat with odd parity → parity bit 1.
- FIFO full: write 17 bytes 0x00..0x10 in consecutive cycles with FIFO_DEPTH=16 →
  - first byte is popped one cycle after its write, so all 17 are accepted;
  - wr_ready_o=0 with fifo_count_o=16 until the next pop;
  - 17 back-to-back frames, 1-cycle gaps, bytes emitted in order.
- Clear and break:
  - Load 4 bytes, assert fifo_clr_i during the first frame → the first frame completes, nothing follows, thre_o=1 next cycle.
  - Assert break_i mid-frame → tx_o=0 immediately; busy_o timing unchanged.
- Reset: assert rst mid-DATA → tx_o=1, busy_o=0, fifo_count_o=0 with no clk edge; after release, a new write 0x55 transmits a correct frame.
- Divisor 0: div=0, write 0x0F (5 data bits) → behaves as div=1: 16-cycle bits 1,1,1,1,0.
